// File: rtl/spi_pkg.sv
// Shared constants and encodings for the SPI slave: default word size,
// sck edge classification and the controller state type.
package spi_pkg;

    localparam int SPI_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        EDGE_NONE  = 2'b00,
        EDGE_LEAD  = 2'b01,
        EDGE_TRAIL = 2'b10
    } edge_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Leading edge leaves the idle level, trailing edge returns to it.
    function automatic edge_e classify_edge(input logic prev, input logic cur, input logic cpol);
        if (prev == cur)
            return EDGE_NONE;
        else if (prev == cpol)
            return EDGE_LEAD;
        else
            return EDGE_TRAIL;
    endfunction

    function automatic edge_e sample_edge_sel(input logic cpha);
        return cpha ? EDGE_TRAIL : EDGE_LEAD;
    endfunction

    function automatic edge_e shift_edge_sel(input logic cpha);
        return cpha ? EDGE_LEAD : EDGE_TRAIL;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser with selectable depth and reset level.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sr <= {STAGES{RST_VAL}};
        else
            sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_slave_multi.sv
// SPI slave, all four modes, oversampled on clk with synchronised pins.
//
//   state     | meaning
//   ST_IDLE   | cs high: counters and shift registers held at zero
//   ST_ACTIVE | frame open: sampling mosi, shifting miso, counting words
module spi_slave_multi
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH_DEFAULT,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sck,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] data,
    output logic             rdy,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_req,
    output logic [7:0]       word_cnt,
    output logic             frame_err
);

    localparam int    CW          = $clog2(WIDTH + 1);
    localparam edge_e SAMPLE_EDGE = sample_edge_sel(CPHA);
    localparam edge_e SHIFT_EDGE  = shift_edge_sel(CPHA);

    logic sck_s, cs_s, mosi_s;
    logic sck_d, cs_d;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
        .clk(clk), .reset(reset), .d(sck), .q(sck_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(cs), .q(cs_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi), .q(mosi_s)
    );

    spi_state_e       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] tx_sr;
    edge_e            sck_edge;
    logic             word_done;

    assign sck_edge  = classify_edge(sck_d, sck_s, CPOL);
    assign word_done = (bit_cnt == CW'(WIDTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sck_d     <= CPOL;
            cs_d      <= 1'b1;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            data      <= '0;
            rdy       <= 1'b0;
            tx_req    <= 1'b0;
            frame_err <= 1'b0;
            word_cnt  <= '0;
            miso      <= 1'b0;
        end else begin
            sck_d     <= sck_s;
            cs_d      <= cs_s;
            rdy       <= 1'b0;
            tx_req    <= 1'b0;
            frame_err <= 1'b0;

            // A fully shifted word is delivered even if cs rises on this clk.
            if (word_done) begin
                data <= rx_sr;
                rdy  <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_d && !cs_s) begin
                        state  <= ST_ACTIVE;
                        tx_sr  <= tx_data;
                        tx_req <= 1'b1;
                        if (!CPHA)
                            miso <= tx_data[WIDTH-1];
                    end
                end
                ST_ACTIVE: begin
                    if (cs_s) begin
                        state    <= ST_IDLE;
                        bit_cnt  <= '0;
                        rx_sr    <= '0;
                        tx_sr    <= '0;
                        word_cnt <= '0;
                        miso     <= 1'b0;
                        if (bit_cnt != '0 && !word_done)
                            frame_err <= 1'b1;
                    end else if (word_done) begin
                        bit_cnt <= '0;
                        tx_sr   <= tx_data;
                        tx_req  <= 1'b1;
                        if (word_cnt != 8'hFF)
                            word_cnt <= word_cnt + 8'd1;
                        if (!CPHA)
                            miso <= tx_data[WIDTH-1];
                    end else begin
                        if (sck_edge == SAMPLE_EDGE) begin
                            rx_sr   <= {rx_sr[WIDTH-2:0], mosi_s};
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                        // In CPHA=0 the trailing edge that closes a word must not
                        // shift out the MSB of the freshly loaded next word.
                        if (sck_edge == SHIFT_EDGE && (CPHA || bit_cnt != '0)) begin
                            miso  <= CPHA ? tx_sr[WIDTH-1] : tx_sr[WIDTH-2];
                            tx_sr <= tx_sr << 1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_multi.sv
// Directed bench for spi_slave_multi: three instances (mode 0 W8, mode 3 W8, mode 1 W12).
module tb_spi_slave_multi;

    logic        clk;
    logic        reset;
    logic [2:0]  sck, cs, mosi;
    logic [2:0]  miso, rdy, tx_req, ferr;
    logic [7:0]  data0, data1, tx0, tx1, wc0, wc1, wc2;
    logic [11:0] data2, tx2;

    spi_slave_multi #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u0 (
        .clk(clk), .reset(reset), .sck(sck[0]), .cs(cs[0]), .mosi(mosi[0]),
        .miso(miso[0]), .data(data0), .rdy(rdy[0]), .tx_data(tx0),
        .tx_req(tx_req[0]), .word_cnt(wc0), .frame_err(ferr[0])
    );
    spi_slave_multi #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) u1 (
        .clk(clk), .reset(reset), .sck(sck[1]), .cs(cs[1]), .mosi(mosi[1]),
        .miso(miso[1]), .data(data1), .rdy(rdy[1]), .tx_data(tx1),
        .tx_req(tx_req[1]), .word_cnt(wc1), .frame_err(ferr[1])
    );
    spi_slave_multi #(.WIDTH(12), .CPOL(1'b0), .CPHA(1'b1)) u2 (
        .clk(clk), .reset(reset), .sck(sck[2]), .cs(cs[2]), .mosi(mosi[2]),
        .miso(miso[2]), .data(data2), .rdy(rdy[2]), .tx_data(tx2),
        .tx_req(tx_req[2]), .word_cnt(wc2), .frame_err(ferr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          half     = 8;
    int          rdy_cnt [3];
    int          txr_cnt [3];
    int          err_cnt [3];
    logic [31:0] miso_acc [3];
    logic [7:0]  u1_words [$];

    initial begin
        for (int i = 0; i < 3; i++) begin
            rdy_cnt[i] = 0; txr_cnt[i] = 0; err_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rdy[i])    rdy_cnt[i]++;
            if (tx_req[i]) txr_cnt[i]++;
            if (ferr[i])   err_cnt[i]++;
        end
        if (rdy[1]) u1_words.push_back(data1);
    end

    function automatic bit cpol_of(input int u);  return (u == 1); endfunction
    function automatic bit cpha_of(input int u);  return (u != 0); endfunction
    function automatic int width_of(input int u); return (u == 2) ? 12 : 8; endfunction

    function automatic logic [31:0] get_data(input int u);
        case (u)
            0:       return {24'd0, data0};
            1:       return {24'd0, data1};
            default: return {20'd0, data2};
        endcase
    endfunction

    function automatic logic [31:0] get_wc(input int u);
        case (u)
            0:       return {24'd0, wc0};
            1:       return {24'd0, wc1};
            default: return {24'd0, wc2};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_tx(input int u, input logic [31:0] v);
        case (u)
            0:       tx0 = v[7:0];
            1:       tx1 = v[7:0];
            default: tx2 = v[11:0];
        endcase
    endtask

    task automatic cs_low(input int u);
        sck[u] = cpol_of(u);
        cs[u]  = 1'b0;
        tick(2 * half);
    endtask

    task automatic cs_high(input int u);
        tick(half);
        cs[u] = 1'b1;
        tick(2 * half + 4);
    endtask

    // Master side: drives mosi/sck and samples miso where a master would.
    task automatic send_bits(input int u, input logic [31:0] word, input int first, input int count);
        int  b;
        bit  cp;
        cp = cpol_of(u);
        for (int i = first; i < first + count; i++) begin
            b = width_of(u) - 1 - i;
            if (!cpha_of(u)) begin
                mosi[u] = word[b];
                tick(half);
                miso_acc[u][b] = miso[u];
                sck[u] = ~cp;
                tick(half);
                sck[u] = cp;
            end else begin
                sck[u]  = ~cp;
                mosi[u] = word[b];
                tick(half);
                miso_acc[u][b] = miso[u];
                sck[u] = cp;
                tick(half);
            end
        end
    endtask

    typedef struct {
        int          u;
        logic [31:0] word;
        int          nbits;
        logic [31:0] tx;
        logic [31:0] exp_data;
        int          exp_rdy;
        int          exp_err;
        int          exp_txr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int r0, t0, e0, r1, t1, e1;
        logic [31:0] wmask;

        vecs[0] = '{0, 32'h0A5,  8, 32'h03C, 32'h0A5, 1, 0, 2};
        vecs[1] = '{0, 32'h0FF,  5, 32'h03C, 32'h0A5, 0, 1, 1};
        vecs[2] = '{2, 32'h3D6, 12, 32'h5F0, 32'h3D6, 1, 0, 2};
        vecs[3] = '{1, 32'h03C,  8, 32'h096, 32'h03C, 1, 0, 2};
        vecs[4] = '{0, 32'h000,  8, 32'h0FF, 32'h000, 1, 0, 2};
        vecs[5] = '{2, 32'h123,  7, 32'h000, 32'h3D6, 0, 1, 1};
        vecs[6] = '{1, 32'h0FF,  3, 32'h000, 32'h03C, 0, 1, 1};

        reset = 1'b0;
        sck   = 3'b010;
        cs    = 3'b111;
        mosi  = 3'b000;
        tx0 = '0; tx1 = '0; tx2 = '0;
        for (int i = 0; i < 3; i++) miso_acc[i] = '0;
        tick(3);
        check("reset_data0", get_data(0), 32'h0);
        check("reset_data1", get_data(1), 32'h0);
        check("reset_data2", get_data(2), 32'h0);
        check("reset_pulses_miso", {20'd0, rdy, tx_req, ferr, miso}, 32'h0);
        check("reset_wcnt", {8'd0, wc0, wc1, wc2}, 32'h0);
        reset = 1'b1;
        tick(6);

        for (int k = 0; k < 7; k++) begin
            int u;
            u = vecs[k].u;
            r0 = rdy_cnt[u]; t0 = txr_cnt[u]; e0 = err_cnt[u];
            set_tx(u, vecs[k].tx);
            miso_acc[u] = '0;
            cs_low(u);
            send_bits(u, vecs[k].word, 0, vecs[k].nbits);
            cs_high(u);
            check($sformatf("v%0d_data", k), get_data(u), vecs[k].exp_data);
            check($sformatf("v%0d_rdy", k), rdy_cnt[u] - r0, vecs[k].exp_rdy);
            check($sformatf("v%0d_ferr", k), err_cnt[u] - e0, vecs[k].exp_err);
            check($sformatf("v%0d_txreq", k), txr_cnt[u] - t0, vecs[k].exp_txr);
            check($sformatf("v%0d_wcnt_idle", k), get_wc(u), 32'h0);
            if (vecs[k].nbits == width_of(u)) begin
                wmask = (32'h1 << width_of(u)) - 32'h1;
                check($sformatf("v%0d_miso", k), miso_acc[u] & wmask, vecs[k].tx);
            end
        end

        // Mode 3: two words back to back in one frame.
        tx1 = 8'h81;
        r1 = rdy_cnt[1]; t1 = txr_cnt[1]; e1 = err_cnt[1];
        u1_words.delete();
        cs_low(1);
        miso_acc[1] = '0;
        send_bits(1, 32'h5A, 0, 8);
        check("m3_miso_w1", miso_acc[1] & 32'hFF, 32'h81);
        check("m3_wcnt_1", get_wc(1), 32'd1);
        miso_acc[1] = '0;
        send_bits(1, 32'hC3, 0, 8);
        check("m3_miso_w2", miso_acc[1] & 32'hFF, 32'h81);
        tick(4);
        check("m3_wcnt_2", get_wc(1), 32'd2);
        check("m3_txreq", txr_cnt[1] - t1, 32'd3);
        cs_high(1);
        check("m3_rdy", rdy_cnt[1] - r1, 32'd2);
        check("m3_nwords", u1_words.size(), 32'd2);
        if (u1_words.size() == 2) begin
            check("m3_word0", {24'd0, u1_words[0]}, 32'h5A);
            check("m3_word1", {24'd0, u1_words[1]}, 32'hC3);
        end
        check("m3_ferr", err_cnt[1] - e1, 32'd0);
        check("m3_wcnt_idle", get_wc(1), 32'd0);

        // WIDTH=12 mode 1: nothing must complete at bit 8.
        r0 = rdy_cnt[2]; e0 = err_cnt[2];
        cs_low(2);
        send_bits(2, 32'hABC, 0, 8);
        tick(4);
        check("w12_no_rdy_at8", rdy_cnt[2] - r0, 32'd0);
        check("w12_data_held", get_data(2), 32'h3D6);
        send_bits(2, 32'hABC, 8, 4);
        tick(4);
        check("w12_rdy", rdy_cnt[2] - r0, 32'd1);
        check("w12_data", get_data(2), 32'hABC);
        cs_high(2);
        check("w12_ferr", err_cnt[2] - e0, 32'd0);

        // Receive at the minimum clk:sck ratio of 4.
        half = 2;
        r0 = rdy_cnt[0];
        cs_low(0);
        send_bits(0, 32'h69, 0, 8);
        cs_high(0);
        check("fast_data", get_data(0), 32'h69);
        check("fast_rdy", rdy_cnt[0] - r0, 32'd1);
        half = 8;

        // sck activity while deselected.
        r0 = rdy_cnt[0]; t0 = txr_cnt[0];
        begin
            logic miso_seen;
            miso_seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                sck[0] = ~sck[0];
                mosi[0] = ~mosi[0];
                tick(2);
                miso_seen = miso_seen | miso[0];
            end
            sck[0] = 1'b0;
            tick(6);
            check("cshi_miso", {31'd0, miso_seen}, 32'd0);
        end
        check("cshi_rdy", rdy_cnt[0] - r0, 32'd0);
        check("cshi_txreq", txr_cnt[0] - t0, 32'd0);
        check("cshi_wcnt", get_wc(0), 32'd0);

        // Reset in the middle of a word.
        tx0 = 8'h00;
        cs_low(0);
        send_bits(0, 32'hF0, 0, 4);
        reset = 1'b0;
        tick(2);
        check("rst_mid_data", {get_data(0)[7:0], get_data(1)[7:0], get_data(2)[15:0]}, 32'h0);
        check("rst_mid_pulses_miso", {20'd0, rdy, tx_req, ferr, miso}, 32'h0);
        check("rst_mid_wcnt", {8'd0, wc0, wc1, wc2}, 32'h0);
        cs[0] = 1'b1; sck[0] = 1'b0; mosi[0] = 1'b0;
        tick(4);
        r0 = rdy_cnt[0]; e0 = err_cnt[0];
        reset = 1'b1;
        tick(20);
        check("rst_after_rdy", rdy_cnt[0] - r0, 32'd0);
        check("rst_after_ferr", err_cnt[0] - e0, 32'd0);
        cs_low(0);
        send_bits(0, 32'h81, 0, 8);
        cs_high(0);
        check("rst_new_data", get_data(0), 32'h81);
        check("rst_new_rdy", rdy_cnt[0] - r0, 32'd1);
        check("rst_new_ferr", err_cnt[0] - e0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
